pipe_stall_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline: PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
- Combines the ID-stage load-use stall request, an EX-stage multi-cycle operation (iterative mul/div) and a flush request.
- Produces one stall vector that every pipeline register and PC consume.
- Owns the multi-cycle EX sequencer FSM and its cycle counter.

---
 rtl/pipe_stall_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline, with the multi-cycle EX sequencer.
// Optional stall/flush performance counters are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
   parameter int MC_CNT_W = 6
`ifdef STALL_PERF_CNT_EN
   ,
   parameter int PERF_W = 32
`endif
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                stallreq_id,
   input  logic                ex_mc_start,
   input  logic [MC_CNT_W-1:0] ex_mc_cycles,
   input  logic                flush_req,
   output logic [5:0]          stall,
   output logic                flush,
   output logic                ex_mc_busy,
   output logic                ex_mc_done
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]   perf_stall_cnt,
   output logic [PERF_W-1:0]   perf_flush_cnt
`else
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mc_state_t;

   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;

   mc_state_t           state_r;
   mc_state_t           next_state_s;
   logic [MC_CNT_W-1:0] cnt_r;
   logic [MC_CNT_W-1:0] cnt_next_s;
   logic                ex_stall_s;
   logic                busy_s;
   logic                done_s;

   // Sequencer state and remaining-cycle counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
         cnt_r   <= {MC_CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state logic and raw EX stall/busy/done before flush masking
   always_comb begin
      next_state_s = state_r;
      cnt_next_s   = cnt_r;
      ex_stall_s   = 1'b0;
      busy_s       = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (ex_mc_start && (ex_mc_cycles >= MC_CNT_W'(2))) begin
               ex_stall_s   = 1'b1;
               busy_s       = 1'b1;
               cnt_next_s   = ex_mc_cycles - MC_CNT_W'(1);
               next_state_s = RUN;
            end else if (ex_mc_start && (ex_mc_cycles == MC_CNT_W'(1))) begin
               ex_stall_s   = 1'b1;
               busy_s       = 1'b1;
               next_state_s = DONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            ex_stall_s = 1'b1;
            busy_s     = 1'b1;
            cnt_next_s = cnt_r - MC_CNT_W'(1);
            if (cnt_r == MC_CNT_W'(1)) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE: begin
            done_s       = 1'b1;
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
            cnt_next_s   = {MC_CNT_W{1'b0}};
         end
      endcase
      // A flush aborts any op outright: no done pulse, counter cleared.
      if (flush_req) begin
         next_state_s = IDLE;
         cnt_next_s   = {MC_CNT_W{1'b0}};
      end else begin
         cnt_next_s = cnt_next_s;
      end
   end

   // Priority merge: flush over EX multi-cycle over load-use; all quiet in reset
   always_comb begin
      stall      = 6'b000000;
      flush      = 1'b0;
      ex_mc_busy = 1'b0;
      ex_mc_done = 1'b0;
      if (!resetn) begin
         stall = 6'b000000;
      end else if (flush_req) begin
         flush = 1'b1;
      end else begin
         ex_mc_busy = busy_s;
         ex_mc_done = done_s;
         if (ex_stall_s) begin
            stall = STALL_EX;
         end else if (stallreq_id) begin
            stall = STALL_ID;
         end else begin
            stall = 6'b000000;
         end
      end
   end

`ifdef STALL_PERF_CNT_EN
   // Saturating counts of stalled cycles and flush cycles
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_stall_cnt <= {PERF_W{1'b0}};
         perf_flush_cnt <= {PERF_W{1'b0}};
      end else begin
         if (stall[0] && !flush_req && (perf_stall_cnt != {PERF_W{1'b1}})) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
         end else begin
            perf_stall_cnt <= perf_stall_cnt;
         end
         if (flush_req && (perf_flush_cnt != {PERF_W{1'b1}})) begin
            perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
         end else begin
            perf_flush_cnt <= perf_flush_cnt;
         end
      end
   end
`else
`endif

endmodule
